// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the 2:1 memory arbiter.
// Grant codes and FSM states used by mem_arbiter_2to1 and mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam int ADDR_W_DEF     = 28;
    localparam int DATA_W_DEF     = 128;
    localparam int STARVE_LIM_DEF = 4;
    localparam int CNT_W_DEF      = 16;
    localparam int STARVE_W       = 4;

    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: D first, I once it has been
// passed over STARVE_LIM times; a port showing ready is masked.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic                i_mask,
    input  logic                d_mask,
    input  logic [STARVE_W-1:0] starve_cnt,
    output gnt_t                gnt
);

    logic i_live;
    logic d_live;
    logic force_i;
    logic d_win;
    logic i_win;

    always_comb begin
        i_live  = i_req & ~i_mask;
        d_live  = d_req & ~d_mask;
        force_i = i_live & d_live &
                  (starve_cnt >= STARVE_W'(STARVE_LIM));
        d_win   = d_live & ~force_i;
        i_win   = i_live & ~d_win;
        gnt     = GNT_NONE;
        unique case (1'b1)
            d_win:   gnt = GNT_D;
            i_win:   gnt = GNT_I;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two-port block arbiter in front of one slow memory port.
// Build with MEMARB_PERF_EN to add grant/wait performance counters.
module mem_arbiter_2to1
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
`ifdef MEMARB_PERF_EN
    ,
    parameter int CNT_W      = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEMARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_gnt_i,
    output logic [CNT_W-1:0]  perf_gnt_d,
    output logic [CNT_W-1:0]  perf_wait_i
`endif
);

    state_t              state_q, state_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic i_req;
    logic d_req;
    logic i_pend;
    gnt_t gnt;

    assign i_req  = i_read | i_write;
    assign d_req  = d_read | d_write;
    assign i_pend = i_req & ~i_ready_q;

    mem_arb_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .i_mask     (i_ready_q),
        .d_mask     (d_ready_q),
        .starve_cnt (starve_q),
        .gnt        (gnt)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = i_req ? starve_q : '0;
        unique case (state_q)
            IDLE: begin
                unique case (gnt)
                    GNT_I: begin
                        state_d  = BUSY_I;
                        rd_d     = i_read & ~i_write;
                        wr_d     = i_write;
                        addr_d   = i_addr;
                        wdata_d  = i_wdata;
                        starve_d = '0;
                    end
                    GNT_D: begin
                        state_d = BUSY_D;
                        rd_d    = d_read & ~d_write;
                        wr_d    = d_write;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (i_pend && starve_q != STARVE_MAX)
                            starve_d = starve_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    i_ready_d = 1'b1;
                    i_rdata_d = wr_q ? '0 : mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = wr_q ? '0 : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
        end
    end

    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

`ifdef MEMARB_PERF_EN
    logic [CNT_W-1:0] gnt_i_q, gnt_i_d;
    logic [CNT_W-1:0] gnt_d_q, gnt_d_d;
    logic [CNT_W-1:0] wait_i_q, wait_i_d;
    logic             idle_gnt_i;
    logic             idle_gnt_d;

    // I is waiting whenever it asks and is neither being served nor granted.
    always_comb begin
        idle_gnt_i = (state_q == IDLE) && (gnt == GNT_I);
        idle_gnt_d = (state_q == IDLE) && (gnt == GNT_D);
        gnt_i_d    = gnt_i_q;
        gnt_d_d    = gnt_d_q;
        wait_i_d   = wait_i_q;
        if (idle_gnt_i && gnt_i_q != '1)
            gnt_i_d = gnt_i_q + 1'b1;
        if (idle_gnt_d && gnt_d_q != '1)
            gnt_d_d = gnt_d_q + 1'b1;
        if (i_pend && state_q != BUSY_I && !idle_gnt_i &&
            wait_i_q != '1)
            wait_i_d = wait_i_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_i_q  <= '0;
            gnt_d_q  <= '0;
            wait_i_q <= '0;
        end else begin
            gnt_i_q  <= gnt_i_d;
            gnt_d_q  <= gnt_d_d;
            wait_i_q <= wait_i_d;
        end
    end

    assign perf_gnt_i  = gnt_i_q;
    assign perf_gnt_d  = gnt_d_q;
    assign perf_wait_i = wait_i_q;
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Self-checking bench for mem_arbiter_2to1: directed steps then random
// traffic against a transaction-level reference model.
module tb_mem_arbiter_2to1;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int LIM = 4;
    localparam int CW  = 4;

    typedef struct {
        bit            v;
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
`ifdef MEMARB_PERF_EN
    logic [CW-1:0] perf_gnt_i, perf_gnt_d, perf_wait_i;
`endif

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (LIM)
`ifdef MEMARB_PERF_EN
        ,
        .CNT_W      (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef MEMARB_PERF_EN
        ,
        .perf_gnt_i  (perf_gnt_i),
        .perf_gnt_d  (perf_gnt_d),
        .perf_wait_i (perf_wait_i)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model: who owns the memory and what it was asked to do
    int            m_own;
    bit            m_rd, m_wr;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_w;
    bit            m_ri, m_rdd;
    logic [DW-1:0] m_xi, m_xd;
    int            m_starve;
    int            m_gi, m_gd, m_wi;
    logic [AW-1:0] mlog[$];
    logic [AW-1:0] dlog[$];

    req_t cur_i, cur_d;
    req_t iq[$];
    req_t dq[$];
    int   mcnt, lat;
    bit   fixed_rd;
    logic [DW-1:0] fixed_val;
    bit   dut_busy_prev;
    int   dut_pulse_i, dut_pulse_d;
    logic [DW-1:0] last_i_rdata;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic req_t mk(bit rd, bit wr, logic [AW-1:0] a,
                                logic [DW-1:0] w);
        req_t r;
        r.v = 1'b1; r.rd = rd; r.wr = wr; r.a = a; r.w = w;
        return r;
    endfunction

    function automatic req_t rand_req();
        int op = $urandom_range(0, 9);
        return mk(op < 5 || op == 9, op >= 5, AW'($urandom), rnd128());
    endfunction

    function automatic int sat(int v, int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_own = 0; m_rd = 0; m_wr = 0; m_a = '0; m_w = '0;
        m_ri = 0; m_rdd = 0; m_xi = '0; m_xd = '0; m_starve = 0;
        m_gi = 0; m_gd = 0; m_wi = 0;
        mlog.delete(); dlog.delete(); iq.delete(); dq.delete();
        cur_i.v = 0; cur_d.v = 0; mcnt = 0; dut_busy_prev = 0;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        mem_ready = 0;
    endtask

    // One clock of the arbitration rules, applied to the inputs just driven.
    task automatic model_edge();
        bit pi, pd, ni, nd;
        int g, own0;
        pi = (i_read || i_write) && !m_ri;
        pd = (d_read || d_write) && !m_rdd;
        ni = 0; nd = 0; g = 0; own0 = m_own;
        if (m_own == 0) begin
            if (pi && pd) g = (m_starve >= LIM) ? 1 : 2;
            else if (pi) g = 1;
            else if (pd) g = 2;
        end else if (mem_ready) begin
            if (m_own == 1) begin ni = 1; m_xi = m_wr ? '0 : mem_rdata; end
            else begin nd = 1; m_xd = m_wr ? '0 : mem_rdata; end
            m_own = 0; m_rd = 0; m_wr = 0;
        end
        if (pi && own0 != 1 && g != 1) m_wi = sat(m_wi, (1 << CW) - 1);
        if (!(i_read || i_write)) m_starve = 0;
        if (g == 1) begin
            m_starve = 0; m_gi = sat(m_gi, (1 << CW) - 1);
            m_own = 1; m_wr = i_write; m_rd = i_read && !i_write;
            m_a = i_addr; m_w = i_wdata; mlog.push_back(i_addr);
        end
        if (g == 2) begin
            if (pi) m_starve = sat(m_starve, 15);
            m_gd = sat(m_gd, (1 << CW) - 1);
            m_own = 2; m_wr = d_write; m_rd = d_read && !d_write;
            m_a = d_addr; m_w = d_wdata; mlog.push_back(d_addr);
        end
        m_ri = ni; m_rdd = nd;
    endtask

    task automatic drive();
        if (m_ri) cur_i.v = 0;
        if (m_rdd) cur_d.v = 0;
        if (!cur_i.v && iq.size() > 0) cur_i = iq.pop_front();
        if (!cur_d.v && dq.size() > 0) cur_d = dq.pop_front();
        i_read = cur_i.v && cur_i.rd; i_write = cur_i.v && cur_i.wr;
        i_addr = cur_i.a; i_wdata = cur_i.w;
        d_read = cur_d.v && cur_d.rd; d_write = cur_d.v && cur_d.wr;
        d_addr = cur_d.a; d_wdata = cur_d.w;
        if ((i_read && i_write) || (d_read && d_write))
            $display("note: read+write raised together on one port");
        if (mem_ready) mem_ready = 0;
        else if (m_rd || m_wr) begin
            mcnt++;
            if (mcnt >= lat) begin
                mem_ready = 1; mcnt = 0;
                mem_rdata = fixed_rd ? fixed_val : rnd128();
            end
        end
    endtask

    task automatic compare();
        chk("mem_read", mem_read, m_rd);
        chk("mem_write", mem_write, m_wr);
        chk("mem_addr", mem_addr, m_a);
        chk("mem_wdata", mem_wdata, m_w);
        chk("i_ready", i_ready, m_ri);
        chk("d_ready", d_ready, m_rdd);
        if (m_ri) chk("i_rdata", i_rdata, m_xi);
        if (m_rdd) chk("d_rdata", d_rdata, m_xd);
`ifdef MEMARB_PERF_EN
        chk("perf_gnt_i", perf_gnt_i, DW'(m_gi));
        chk("perf_gnt_d", perf_gnt_d, DW'(m_gd));
        chk("perf_wait_i", perf_wait_i, DW'(m_wi));
`endif
        if ((mem_read || mem_write) && !dut_busy_prev) dlog.push_back(mem_addr);
        dut_busy_prev = mem_read || mem_write;
        if (i_ready) begin dut_pulse_i++; last_i_rdata = i_rdata; end
        if (d_ready) dut_pulse_d++;
    endtask

    task automatic cyc();
        drive();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit idle = 0;
        while (!idle && n < budget) begin
            cyc(); n++;
            idle = m_own == 0 && !m_ri && !m_rdd && !cur_i.v &&
                   !cur_d.v && iq.size() == 0 && dq.size() == 0;
        end
        chk("drain_done", idle, 1'b1);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_ngrants"}, dlog.size(), mlog.size());
        for (int k = 0; k < dlog.size() && k < mlog.size(); k++)
            chk({tag, "_grant_addr"}, dlog[k], mlog[k]);
        dlog.delete(); mlog.delete();
    endtask

    initial begin
        logic [DW-1:0] pat;
        int p0;
        rst_n = 0; fixed_rd = 0; fixed_val = '0; lat = 5;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        mem_rdata = '0; dut_pulse_i = 0; dut_pulse_d = 0;
        last_i_rdata = '0;
        model_reset();
        @(negedge clk);
        compare();
        @(negedge clk);
        rst_n = 1;

        // single I read
        fixed_rd = 1; fixed_val = {16{8'hA5}};
        p0 = dut_pulse_i;
        iq.push_back(mk(1, 0, 28'h0000010, '0));
        drain(60);
        chk("s1_pulses", dut_pulse_i - p0, 1);
        chk("s1_rdata", last_i_rdata, {16{8'hA5}});
        chk("s1_read_low", mem_read, 1'b0);
        chk("s1_first", dlog[0], 28'h0000010);
        check_log("s1");
        fixed_rd = 0;

        // simultaneous I read and D write: D first
        iq.push_back(mk(1, 0, 28'h0000100, '0));
        dq.push_back(mk(0, 1, 28'h0000200, rnd128()));
        drain(80);
        chk("s2_first", dlog[0], 28'h0000200);
        chk("s2_second", dlog[1], 28'h0000100);
        check_log("s2");

        // D streaming with I waiting
        for (int k = 0; k < 6; k++)
            dq.push_back(mk(1, 0, AW'(28'h300 + k), '0));
        iq.push_back(mk(1, 0, 28'h0000400, '0));
        drain(200);
        check_log("s3");

        // D write data held stable for a long memory latency
        lat = 8;
        pat = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;
        dq.push_back(mk(0, 1, 28'h0ABCDEF, pat));
        drain(60);
        chk("s4_addr", dlog[0], 28'h0ABCDEF);
        chk("s4_wdata", mem_wdata, pat);
        check_log("s4");

        // reset in the middle of a D transaction
        lat = 20;
        dq.push_back(mk(0, 1, 28'h0000555, rnd128()));
        for (int k = 0; k < 10 && m_own != 2; k++) cyc();
        cyc(); cyc();
        chk("s5_busy", mem_write, 1'b1);
        rst_n = 0;
        #1;
        chk("s5_wr_drop", mem_write, 1'b0);
        chk("s5_ready_low", d_ready, 1'b0);
        chk("s5_addr_zero", mem_addr, '0);
        chk("s5_wdata_zero", mem_wdata, '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        p0 = dut_pulse_d;
        for (int k = 0; k < 30; k++) cyc();
        chk("s5_no_stale", dut_pulse_d - p0, 0);

`ifdef MEMARB_PERF_EN
        lat = 2;
        for (int k = 0; k < 3; k++) iq.push_back(mk(1, 0, AW'(k), '0));
        for (int k = 0; k < 2; k++) dq.push_back(mk(1, 0, AW'(k + 8), '0));
        drain(100);
        chk("p_gnt_i", perf_gnt_i, 3);
        chk("p_gnt_d", perf_gnt_d, 2);
        for (int k = 0; k < 20; k++) iq.push_back(mk(1, 0, AW'(k), '0));
        drain(300);
        chk("p_gnt_i_sat", perf_gnt_i, (1 << CW) - 1);
        check_log("p");
`endif

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0 && iq.size() < 2)
                iq.push_back(rand_req());
            if ($urandom_range(0, 2) == 0 && dq.size() < 2)
                dq.push_back(rand_req());
            if (mem_ready) lat = $urandom_range(1, 6);
            cyc();
        end
        drain(300);
        check_log("rnd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
